// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the host/core memory arbiter.
package mem_arbiter_pkg;

   localparam int MEM_ADDR_WIDTH = 10;
   localparam int DATAPATH_WIDTH = 64;
   localparam int LOCK_MAX_DEF   = 16;

   typedef enum logic [1:0] {
      ARB_RR    = 2'd0,
      ARB_LOCK  = 2'd1,
      ARB_YIELD = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic vld;
      logic host;
   } rtag_t;

endpackage

// File: rtl/mem_arb_rtag.sv
// Two-stage read owner tag pipeline; routes the memory read return to the
// requester that issued the read.
module mem_arb_rtag
   import mem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic rd_vld,
   input  logic rd_host,
   output logic h_rvalid,
   output logic c_rvalid
);

   rtag_t [1:0] tag_q, tag_d;

   always_comb begin
      tag_d[0] = '{vld: rd_vld, host: rd_host};
      tag_d[1] = tag_q[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tag_q <= '0;
      else        tag_q <= tag_d;
   end

   assign h_rvalid = tag_q[1].vld &  tag_q[1].host;
   assign c_rvalid = tag_q[1].vld & ~tag_q[1].host;

endmodule

// File: rtl/mem_arbiter.sv
// Host/core arbiter for the single-port unified memory, with host burst lock
// and bounded core starvation. Define ARB_STATS_EN to add grant/conflict counters.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = DATAPATH_WIDTH,
   parameter int LOCK_MAX   = LOCK_MAX_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  h_req,
   input  logic                  h_wr,
   input  logic                  h_lock,
   input  logic [ADDR_WIDTH-1:0] h_addr,
   input  logic [DATA_WIDTH-1:0] h_wdata,
   output logic                  h_gnt,
   output logic                  h_rvalid,
   output logic [DATA_WIDTH-1:0] h_rdata,
   input  logic                  c_req,
   input  logic                  c_wr,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   input  logic [DATA_WIDTH-1:0] c_wdata,
   output logic                  c_gnt,
   output logic                  c_rvalid,
   output logic [DATA_WIDTH-1:0] c_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]           stat_h_grants,
   output logic [31:0]           stat_c_grants,
   output logic [31:0]           stat_conflicts
`endif
);

   localparam int CW = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

   arb_state_e            state_q, state_d;
   logic                  last_host_q, last_host_d;
   logic [CW-1:0]         lock_cnt_q, lock_cnt_d;
   logic                  h_gnt_c, c_gnt_c;
   logic                  mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      h_gnt_c    = 1'b0;
      c_gnt_c    = 1'b0;
      case (state_q)
         ARB_RR: begin
            if (h_req && (!c_req || !last_host_q)) h_gnt_c = 1'b1;
            else if (c_req)                        c_gnt_c = 1'b1;
            if (h_gnt_c && h_lock) begin
               state_d    = ARB_LOCK;
               lock_cnt_d = CW'(1);
            end
         end
         ARB_LOCK: begin
            h_gnt_c = h_req;
            c_gnt_c = c_req && !h_req;
            if (h_gnt_c && lock_cnt_q != CNT_MAX) lock_cnt_d = lock_cnt_q + CW'(1);
            // Yield is decided on the post-grant count so the core goes right
            // after the LOCK_MAX-th host grant.
            if (!h_lock) begin
               state_d    = ARB_RR;
               lock_cnt_d = '0;
            end else if (c_req && !c_gnt_c && lock_cnt_d == CNT_MAX) begin
               state_d = ARB_YIELD;
            end
         end
         ARB_YIELD: begin
            c_gnt_c = c_req;
            h_gnt_c = h_req && !c_req;
            if (c_gnt_c) begin
               lock_cnt_d = '0;
               state_d    = h_lock ? ARB_LOCK : ARB_RR;
            end
         end
         default: state_d = ARB_RR;
      endcase
   end

   // Grants are held low while reset is asserted.
   assign h_gnt = h_gnt_c & reset;
   assign c_gnt = c_gnt_c & reset;

   always_comb begin
      last_host_d = last_host_q;
      if (h_gnt)      last_host_d = 1'b1;
      else if (c_gnt) last_host_d = 1'b0;
      mem_en_d    = h_gnt | c_gnt;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      if (h_gnt) begin
         mem_we_d    = h_wr;
         mem_addr_d  = h_addr;
         mem_wdata_d = h_wdata;
      end else if (c_gnt) begin
         mem_we_d    = c_wr;
         mem_addr_d  = c_addr;
         mem_wdata_d = c_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ARB_RR;
         last_host_q <= 1'b0;
         lock_cnt_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         last_host_q <= last_host_d;
         lock_cnt_q  <= lock_cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign h_rdata   = mem_rdata;
   assign c_rdata   = mem_rdata;

   mem_arb_rtag u_rtag (
      .clk      (clk),
      .rst_n    (reset),
      .rd_vld   ((h_gnt & ~h_wr) | (c_gnt & ~c_wr)),
      .rd_host  (h_gnt),
      .h_rvalid (h_rvalid),
      .c_rvalid (c_rvalid)
   );

`ifdef ARB_STATS_EN
   logic [31:0] st_h_q, st_h_d, st_c_q, st_c_d, st_x_q, st_x_d;

   always_comb begin
      st_h_d = st_h_q + {31'd0, h_gnt};
      st_c_d = st_c_q + {31'd0, c_gnt};
      st_x_d = st_x_q + {31'd0, h_req & c_req};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_h_q <= '0;
         st_c_q <= '0;
         st_x_q <= '0;
      end else begin
         st_h_q <= st_h_d;
         st_c_q <= st_c_d;
         st_x_q <= st_x_d;
      end
   end

   assign stat_h_grants  = st_h_q;
   assign stat_c_grants  = st_c_q;
   assign stat_conflicts = st_x_q;
`endif

endmodule
